uart_cmd_initiator: RTL

Host-side initiator for the serial command link. It is the opposite end of the LED command parser. It accepts a packed command of 1-4 bytes plus an optional terminator. It sends the bytes one at a time through a uart_tx instance, then waits for a single response byte from a uart_rx instance, with a timeout. It is used for on-FPGA self-test and board-to-board control, wired between user logic and the uart_tx/uart_rx pair.

---
 rtl/uart_cmd_initiator_if.sv | 60 ++++++
 rtl/uart_cmd_initiator.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_initiator_if.sv
// ---------------------------------------------------------------------------
// uart_cmd_initiator_if
//
// Bundles every signal between the command initiator, the user logic that
// issues commands, and the uart_tx / uart_rx pair it drives.
//
// Signal summary:
//   cmd_start   user -> initiator   1-cycle command request
//   cmd_data    user -> initiator   32-bit payload, byte 0 ([7:0]) sent first
//   cmd_len     user -> initiator   payload byte count, 1..4 valid
//   busy        initiator -> user   command in progress
//   cmd_error   initiator -> user   1-cycle pulse on an invalid cmd_len
//   tx_byte     initiator -> tx     byte for uart_tx
//   tx_dv       initiator -> tx     1-cycle load strobe for uart_tx
//   tx_active   tx -> initiator     uart_tx frame in progress
//   tx_done     tx -> initiator     1-cycle pulse at end of stop bit
//   rx_byte     rx -> initiator     byte from uart_rx
//   rx_dv       rx -> initiator     1-cycle byte-valid pulse from uart_rx
//   rsp_byte    initiator -> user   last captured response byte
//   rsp_valid   initiator -> user   1-cycle pulse on response capture
//   rsp_timeout initiator -> user   1-cycle pulse when no response arrived
//
// Modports:
//   master  the initiator itself
//   slave   the environment around it (user logic plus the UART pair)
// ---------------------------------------------------------------------------
interface uart_cmd_initiator_if;
  logic        cmd_start;
  logic [31:0] cmd_data;
  logic [2:0]  cmd_len;
  logic        busy;
  logic        cmd_error;
  logic [7:0]  tx_byte;
  logic        tx_dv;
  logic        tx_active;
  logic        tx_done;
  logic [7:0]  rx_byte;
  logic        rx_dv;
  logic [7:0]  rsp_byte;
  logic        rsp_valid;
  logic        rsp_timeout;

  modport master (
    input  cmd_start, cmd_data, cmd_len,
    input  tx_active, tx_done,
    input  rx_byte, rx_dv,
    output busy, cmd_error,
    output tx_byte, tx_dv,
    output rsp_byte, rsp_valid, rsp_timeout
  );

  modport slave (
    output cmd_start, cmd_data, cmd_len,
    output tx_active, tx_done,
    output rx_byte, rx_dv,
    input  busy, cmd_error,
    input  tx_byte, tx_dv,
    input  rsp_byte, rsp_valid, rsp_timeout
  );
endinterface

// File: rtl/uart_cmd_initiator.sv
// ---------------------------------------------------------------------------
// uart_cmd_initiator
//
// Host-side end of the serial command link. A command of 1-4 payload bytes
// (optionally followed by a terminator byte) is pushed out one byte at a
// time through uart_tx, after which a single response byte is awaited from
// uart_rx. If the response does not arrive within TIMEOUT_CLKS clocks of the
// final tx_done, a timeout pulse is raised instead.
//
// Parameters:
//   TIMEOUT_CLKS  clocks to wait for the response after the last tx_done (>= 2)
//   APPEND_TERM   1 = send TERM_CHAR after the payload, 0 = payload only
//   TERM_CHAR     terminator byte
//
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset
//   bus   uart_cmd_initiator_if.master (command, uart_tx, uart_rx and
//         response signals)
// ---------------------------------------------------------------------------
module uart_cmd_initiator #(
  parameter int unsigned TIMEOUT_CLKS = 1000000,
  parameter bit          APPEND_TERM  = 1'b1,
  parameter logic [7:0]  TERM_CHAR    = 8'h0D
) (
  input  logic                        clk,
  input  logic                        rst,
  uart_cmd_initiator_if.master        bus
);

  // The counter only has to reach TIMEOUT_CLKS-1, so $clog2 bits suffice.
  localparam int CntW = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;

  // The timeout fires on the edge where the counter would step onto
  // TIMEOUT_CLKS-1, i.e. while it still holds TIMEOUT_CLKS-2.
  localparam logic [CntW-1:0] CntPreLast = CntW'(TIMEOUT_CLKS - 2);

  // Number of extra bytes sent after the payload.
  localparam logic [3:0] TermCnt = APPEND_TERM ? 4'd1 : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_DONE,
    WAIT_RSP
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       data_q, data_d;
  logic [2:0]        len_q, len_d;
  logic [2:0]        idx_q, idx_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [7:0]        rsp_byte_q, rsp_byte_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic              cmd_error_q, cmd_error_d;
  logic              len_ok;
  logic [7:0]        sel_byte;

  assign len_ok = (bus.cmd_len != 3'd0) && (bus.cmd_len <= 3'd4);

  // State and datapath registers; reset aborts any transfer in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      data_q        <= '0;
      len_q         <= '0;
      idx_q         <= '0;
      cnt_q         <= '0;
      rsp_byte_q    <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      cmd_error_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      data_q        <= data_d;
      len_q         <= len_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      rsp_byte_q    <= rsp_byte_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_timeout_q <= rsp_timeout_d;
      cmd_error_q   <= cmd_error_d;
    end
  end

  // Next-state and datapath update. The three status pulses default low so
  // each can only last one cycle; they come from disjoint branches, which
  // keeps them mutually exclusive.
  always_comb begin
    state_d       = state_q;
    data_d        = data_q;
    len_d         = len_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    rsp_byte_d    = rsp_byte_q;
    rsp_valid_d   = 1'b0;
    rsp_timeout_d = 1'b0;
    cmd_error_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_start) begin
          if (len_ok) begin
            data_d  = bus.cmd_data;
            len_d   = bus.cmd_len;
            idx_d   = 3'd0;
            state_d = SEND;
          end else begin
            cmd_error_d = 1'b1;
          end
        end
      end

      SEND: begin
        // Hold off while a previous frame (possibly one orphaned by a
        // reset) is still on the line.
        if (!bus.tx_active) begin
          state_d = WAIT_DONE;
        end
      end

      WAIT_DONE: begin
        if (bus.tx_done) begin
          idx_d = idx_q + 3'd1;
          if ({1'b0, idx_d} < ({1'b0, len_q} + TermCnt)) begin
            state_d = SEND;
          end else begin
            cnt_d   = '0;
            state_d = WAIT_RSP;
          end
        end
      end

      WAIT_RSP: begin
        // A response arriving on the terminal-count cycle still wins.
        if (bus.rx_dv) begin
          rsp_byte_d  = bus.rx_byte;
          rsp_valid_d = 1'b1;
          state_d     = IDLE;
        end else if (cnt_q == CntPreLast) begin
          rsp_timeout_d = 1'b1;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Byte selection: payload bytes in ascending order, then the terminator
  // once the index has run past the payload length.
  always_comb begin
    sel_byte = TERM_CHAR;
    if (idx_q < len_q) begin
      case (idx_q[1:0])
        2'd0: sel_byte = data_q[7:0];
        2'd1: sel_byte = data_q[15:8];
        2'd2: sel_byte = data_q[23:16];
        2'd3: sel_byte = data_q[31:24];
      endcase
    end
  end

  // Outputs decoded from state. tx_dv is combinational so the strobe lands
  // in the first SEND cycle; leaving SEND on that same edge limits it to a
  // single cycle.
  always_comb begin
    bus.busy    = (state_q != IDLE);
    bus.tx_dv   = 1'b0;
    bus.tx_byte = 8'h00;
    if (state_q == SEND) begin
      bus.tx_dv   = !bus.tx_active;
      bus.tx_byte = sel_byte;
    end else if (state_q == WAIT_DONE) begin
      bus.tx_byte = sel_byte;
    end
  end

  assign bus.rsp_byte    = rsp_byte_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.cmd_error   = cmd_error_q;

endmodule
